// File: rtl/mem_pkg.sv
// Shared definitions for the parametrised data memories.
// Holds the default geometry, the two-state controller encoding and a byte-lane helper.
package mem_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DEPTH  = 256;

  // Controller state: sweeping the array, or open for accesses.
  typedef logic [0:0] state_t;
  localparam state_t ST_INIT  = 1'b0;
  localparam state_t ST_READY = 1'b1;

  // Lowest bit index of byte lane 'lane' within a data word.
  function automatic int unsigned lane_lo(input int unsigned lane);
    return lane * 8;
  endfunction

endpackage

// File: rtl/param_data_mem_if.sv
// Access bus of param_data_mem.
// master: addr, wdata, we, be, re, clr out; rdata, rvalid, ready, err in.
// slave : the mirror image, used by the memory itself.
interface param_data_mem_if
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              we;
  logic [BE_W-1:0]   be;
  logic              re;
  logic              clr;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              ready;
  logic              err;

  modport master (
    output addr, wdata, we, be, re, clr,
    input  rdata, rvalid, ready, err
  );

  modport slave (
    input  addr, wdata, we, be, re, clr,
    output rdata, rvalid, ready, err
  );
endinterface

// File: rtl/mem_init_seq.sv
// Init sweep sequencer: walks addr from 0 to DEPTH-1, one word per falling edge.
// Ports: clk, rst (async active-low), start (restart sweep when idle),
//        addr (word being written), wr (sweep write strobe), done (final write this edge).
module mem_init_seq
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] addr,
  output logic              wr,
  output logic              done
);
  // One extra bit so DEPTH = 2**ADDR_W ends without wrapping to 0.
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [CNT_W-1:0] icnt_q;
  logic             busy_q;

  // Counter advances every edge while busy; start rearms it from 0.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      icnt_q <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      icnt_q <= icnt_q + CNT_W'(1);
      if (done) busy_q <= 1'b0;
    end else if (start) begin
      icnt_q <= '0;
      busy_q <= 1'b1;
    end
  end

  assign addr = icnt_q[ADDR_W-1:0];
  assign wr   = busy_q;
  // Combinational so the owner can leave INIT on the same edge as the last write.
  assign done = busy_q && (icnt_q == CNT_W'(DEPTH - 1));

endmodule

// File: rtl/param_data_mem.sv
// Parametrised data memory with byte-enable writes, optional registered read,
// range checking and a hardware init sweep after reset or on clr.
// Ports: clk (state updates on the falling edge), rst (async active-low),
//        bus (param_data_mem_if.slave: addr/wdata/we/be/re/clr in,
//             rdata/rvalid/ready/err out).
module param_data_mem
  import mem_pkg::*;
#(
  parameter int unsigned          DATA_W   = DEF_DATA_W,
  parameter int unsigned          ADDR_W   = DEF_ADDR_W,
  parameter int unsigned          DEPTH    = DEF_DEPTH,
  parameter int unsigned          READ_REG = 0,
  parameter logic [DATA_W-1:0]    INIT_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  param_data_mem_if.slave         bus
);
  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic              err_q, err_d;
  logic              user_wr_c;
  logic              rd_fire_c;
  logic              init_start_c;
  logic [ADDR_W-1:0] init_addr;
  logic              init_wr;
  logic              init_done;
  logic              in_range_c;
  logic [IDX_W-1:0]  idx_c;
  logic [IDX_W-1:0]  init_idx_c;
  logic [DATA_W-1:0] rd_word_c;
  logic [DATA_W-1:0] merged_c;

  mem_init_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_init (
    .clk   (clk),
    .rst   (rst),
    .start (init_start_c),
    .addr  (init_addr),
    .wr    (init_wr),
    .done  (init_done)
  );

  // Range check in ADDR_W+1 bits so DEPTH = 2**ADDR_W compares correctly.
  assign in_range_c = {1'b0, bus.addr} < CNT_W'(DEPTH);
  assign idx_c      = IDX_W'(bus.addr);
  assign init_idx_c = IDX_W'(init_addr);
  assign rd_word_c  = in_range_c ? mem[idx_c] : '0;

  // Byte-lane merge: enabled lanes take wdata, the rest keep the stored word.
  always_comb begin
    merged_c = rd_word_c;
    for (int unsigned i = 0; i < BE_W; i++) begin
      if (bus.be[i]) merged_c[lane_lo(i) +: 8] = bus.wdata[lane_lo(i) +: 8];
    end
  end

  // Controller state and registered error pulse.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_INIT;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Next state and access qualification; clr outranks any same-edge access.
  always_comb begin
    state_d      = state_q;
    err_d        = 1'b0;
    user_wr_c    = 1'b0;
    rd_fire_c    = 1'b0;
    init_start_c = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (init_done) state_d = ST_READY;
      end
      ST_READY: begin
        if (bus.clr) begin
          state_d      = ST_INIT;
          init_start_c = 1'b1;
        end else begin
          user_wr_c = bus.we && in_range_c && (|bus.be);
          rd_fire_c = (READ_REG != 0) && bus.re;
          err_d     = !in_range_c && (bus.we || rd_fire_c);
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Array port: sweep writes in INIT, merged user writes in READY; no reset on contents.
  always_ff @(negedge clk) begin
    if (rst) begin
      if (init_wr)        mem[init_idx_c] <= INIT_VAL;
      else if (user_wr_c) mem[idx_c]      <= merged_c;
    end
  end

  generate
    if (READ_REG != 0) begin : g_rreg
      logic [DATA_W-1:0] rdata_q;
      logic              rvalid_q;

      // Read samples the pre-write word, giving read-before-write on a shared edge.
      always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else begin
          rvalid_q <= rd_fire_c;
          if (rd_fire_c) rdata_q <= rd_word_c;
        end
      end

      assign bus.rdata  = rdata_q;
      assign bus.rvalid = rvalid_q;
    end else begin : g_rcomb
      // Combinational read; forced to 0 while the array is being swept.
      assign bus.rdata  = (state_q == ST_READY) ? rd_word_c : '0;
      assign bus.rvalid = (state_q == ST_READY);
    end
  endgenerate

  assign bus.ready = (state_q == ST_READY);
  assign bus.err   = err_q;

endmodule
